multdiv_seq_ctrl: RTL and testbench
===================================

Name: multdiv_seq_ctrl

Overview:
- Iterative multiply sequencer (radix-2 Booth) for the CPU execute stage.
- Does not instantiate its own 32-bit adder. It time-shares the ALU's 32-bit adder and overflow detector through an adder port group.
- Per iteration it drives the adder operands and carry-in, and samples the sum and overflow the same cycle.
- Raises data_resultRDY after a fixed latency. data_exception flags a product that does not fit in 32 signed bits.

Parameters:
- WIDTH, 32, operand and result width. Iteration count equals WIDTH.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- ctrl_MULT  input  1  start-multiply pulse, sampled only in IDLE
- ctrl_DIV  input  1  start-divide pulse; used only with the optional feature
- data_operandA  input  32  multiplicand / dividend, latched at start
- data_operandB  input  32  multiplier / divisor, latched at start
- adder_a  output  32  shared adder operand A
- adder_b  output  32  shared adder operand B (already inverted for subtract)
- adder_cin  output  1  shared adder carry-in (1 = subtract)
- adder_result  input  32  shared adder sum, combinational from adder_a/adder_b/adder_cin
- adder_overflow  input  1  signed overflow of that sum
- data_result  output  32  low 32 bits of the result, registered
- data_exception  output  1  result overflow / divide-by-zero, registered
- data_resultRDY  output  1  one-cycle completion pulse
- busy  output  1  high in RUN and DONE

Behaviour:
- States: IDLE, RUN, DONE. Reset (any time, including mid-operation):
  - state = IDLE, counter = 0, internal registers = 0
  - data_result = 0, data_exception = 0, data_resultRDY = 0, busy = 0
  - adder_a/adder_b/adder_cin = 0
- IDLE:
  - Drives adder outputs to 0.
  - On a clock edge with ctrl_MULT = 1: latch M = data_operandA; set P[64:0] = {32'b0, data_operandB, 1'b0}; counter = 0; go to RUN.
  - ctrl_MULT and ctrl_DIV high together: MULT wins.
- RUN, each cycle (WIDTH cycles total):
  - adder_a = P[64:33].
  - P[1:0] = 01: adder_b = M, adder_cin = 0.
  - P[1:0] = 10: adder_b = ~M, adder_cin = 1.
  - P[1:0] = 00 or 11: adder_b = 0, adder_cin = 0. The sum equals P[64:33].
  - Next P = {s, adder_result, P[32:1]}, where s = adder_result[31] ^ adder_overflow (sign correction when the intermediate sum overflows).
  - counter increments. When counter == WIDTH-1, go to DONE at that edge.
- DONE (one cycle):
  - data_resultRDY = 1.
  - data_result = P[32:1].
  - data_exception = 1 iff P[64:33] is not all copies of P[32].
  - Next edge: IDLE.
- Latency: ctrl_MULT sampled at edge N → data_resultRDY high from edge N+32 to edge N+33. Back-to-back start is possible at edge N+33.
- data_result and data_exception stay stable after DONE until the next DONE or reset. data_resultRDY is high only in DONE.
- ctrl_MULT or ctrl_DIV asserted while busy is ignored: no restart, no queueing.
- Operand changes after the start edge have no effect.

Optional Feature:
- Macro: MULTDIV_DIV_EN.
- Defined:
  - ctrl_DIV in IDLE starts a restoring signed divide. Magnitudes of A and B are formed by local negation logic.
  - Each RUN cycle: adder computes remainder_shifted − |B| (adder_b = ~|B|, adder_cin = 1). The non-negative check uses adder_result[31] ^ adder_overflow. Quotient bit = 1 if non-negative.
  - DONE: quotient negated if the operand signs differ. Same N+32 latency.
  - B == 0: go straight to DONE at edge N+1 with data_result = 0, data_exception = 1.
- Undefined: ctrl_DIV is ignored. The divide datapath and state decode are absent.

Test Plan:
- Reset, then ctrl_MULT with A=3, B=−4 (0xFFFFFFFC) → data_result = 0xFFFFFFF4, exception = 0, RDY exactly at edge N+32 for one cycle, busy low at N+33.
- A=0x7FFFFFFF, B=2 → data_result = 0xFFFFFFFE, exception = 1.
- A=0x80000000, B=0xFFFFFFFF (overflow-corrected Booth path) → data_result = 0x80000000, exception = 1.
- Start A=5, B=6; at edge N+10 pulse ctrl_MULT with A=7, B=7 → result 30 at N+32, second request ignored. Then reset asserted asynchronously mid-RUN on a new op → all outputs 0 immediately, IDLE, no RDY.
- ctrl_MULT and ctrl_DIV together with A=−6, B=7 → multiply result 0xFFFFFFD6.
- With MULTDIV_DIV_EN: 100 / −7 → 0xFFFFFFF2 (−14), exception = 0, RDY at N+32. 9 / 0 → result 0, exception = 1, RDY at N+1.

Source files
------------

// File: rtl/multdiv_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : multdiv_seq_ctrl
//  Description : Iterative radix-2 Booth multiply sequencer for the execute
//                stage. Borrows the ALU's 32-bit adder and overflow detector
//                through the adder_* port group instead of owning an adder.
//                Optional restoring signed divide enabled by MULTDIV_DIV_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module multdiv_seq_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] adder_a,
    output logic [WIDTH-1:0] adder_b,
    output logic             adder_cin,
    input  logic [WIDTH-1:0] adder_result,
    input  logic             adder_overflow,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int              c_CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic [c_CW-1:0]   r_count;
    logic [2*WIDTH:0]  r_p;        // Booth: {acc_hi, multiplier, guard}; divide: {0, rem, quot}
    logic [WIDTH-1:0]  r_m;        // multiplicand, or |divisor| when dividing

    logic [WIDTH-1:0]  w_booth_b;
    logic              w_booth_cin;
    logic [2*WIDTH:0]  w_mul_next;
    logic              w_mul_ovf;

    // Sum sign corrected for overflow, then arithmetic shift of the whole product
    assign w_mul_next = {adder_result[WIDTH-1] ^ adder_overflow, adder_result, r_p[WIDTH:1]};
    assign w_mul_ovf  = (w_mul_next[2*WIDTH:WIDTH+1] != {WIDTH{w_mul_next[WIDTH]}});

`ifdef MULTDIV_DIV_EN
    logic              r_is_div;
    logic              r_neg;
    logic              r_dz;
    logic [WIDTH-1:0]  w_mag_a;
    logic [WIDTH-1:0]  w_mag_b;
    logic [WIDTH:0]    w_rem_shift;
    logic              w_ge;
    logic [2*WIDTH:0]  w_div_next;
    logic [WIDTH-1:0]  w_quot;
    logic [WIDTH-1:0]  w_quot_signed;
    logic              w_div_ovf;

    assign w_mag_a     = data_operandA[WIDTH-1] ? (~data_operandA + 1'b1) : data_operandA;
    assign w_mag_b     = data_operandB[WIDTH-1] ? (~data_operandB + 1'b1) : data_operandB;
    assign w_rem_shift = {r_p[2*WIDTH-1:WIDTH], r_p[WIDTH-1]};
    // Adder gives a signed compare; flipping by the operand MSBs turns it into
    // an unsigned compare so |B| = 2^(WIDTH-1) and large remainders work. A set
    // bit above the adder width means the shifted remainder already exceeds |B|.
    assign w_ge = w_rem_shift[WIDTH] |
                  ~(adder_result[WIDTH-1] ^ adder_overflow ^ w_rem_shift[WIDTH-1] ^ r_m[WIDTH-1]);
    assign w_div_next    = {1'b0, (w_ge ? adder_result : w_rem_shift[WIDTH-1:0]),
                            r_p[WIDTH-2:0], w_ge};
    assign w_quot        = w_div_next[WIDTH-1:0];
    assign w_quot_signed = r_neg ? (~w_quot + 1'b1) : w_quot;
    // Only most-negative / -1 yields a positive quotient that does not fit
    assign w_div_ovf     = ~r_neg & w_quot[WIDTH-1];
`else
    logic              w_ctrl_div_unused;
    assign w_ctrl_div_unused = ctrl_DIV;
`endif

    // Booth recoding of the two low product bits selects +M, -M or nothing
    always_comb begin
        w_booth_b   = '0;
        w_booth_cin = 1'b0;
        case (r_p[1:0])
            2'b01:   w_booth_b = r_m;
            2'b10: begin
                w_booth_b   = ~r_m;
                w_booth_cin = 1'b1;
            end
            default: ;
        endcase
    end

    // Shared adder is only driven while iterating; zero otherwise
    always_comb begin
        adder_a   = '0;
        adder_b   = '0;
        adder_cin = 1'b0;
        if (r_state == S_RUN) begin
`ifdef MULTDIV_DIV_EN
            if (r_is_div) begin
                adder_a   = w_rem_shift[WIDTH-1:0];
                adder_b   = ~r_m;
                adder_cin = 1'b1;
            end else
`endif
            begin
                adder_a   = r_p[2*WIDTH:WIDTH+1];
                adder_b   = w_booth_b;
                adder_cin = w_booth_cin;
            end
        end
    end

    // Sequencer FSM with registered result, exception, ready and busy
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_count        <= '0;
            r_p            <= '0;
            r_m            <= '0;
`ifdef MULTDIV_DIV_EN
            r_is_div       <= 1'b0;
            r_neg          <= 1'b0;
            r_dz           <= 1'b0;
`endif
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (ctrl_MULT) begin
                        r_m     <= data_operandA;
                        r_p     <= {{WIDTH{1'b0}}, data_operandB, 1'b0};
                        r_count <= '0;
                        r_state <= S_RUN;
                        busy    <= 1'b1;
`ifdef MULTDIV_DIV_EN
                        r_is_div <= 1'b0;
                    end else if (ctrl_DIV) begin
                        r_is_div <= 1'b1;
                        r_m      <= w_mag_b;
                        r_p      <= {1'b0, {WIDTH{1'b0}}, w_mag_a};
                        r_neg    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                        r_dz     <= (data_operandB == '0);
                        r_count  <= '0;
                        r_state  <= S_RUN;
                        busy     <= 1'b1;
`endif
                    end
                end
                S_RUN: begin
                    r_count <= r_count + c_CW'(1);
`ifdef MULTDIV_DIV_EN
                    if (r_is_div) begin
                        r_p <= w_div_next;
                        if (r_dz) begin
                            data_result    <= '0;
                            data_exception <= 1'b1;
                            data_resultRDY <= 1'b1;
                            r_state        <= S_DONE;
                        end else if (r_count == c_LAST) begin
                            data_result    <= w_quot_signed;
                            data_exception <= w_div_ovf;
                            data_resultRDY <= 1'b1;
                            r_state        <= S_DONE;
                        end
                    end else
`endif
                    begin
                        r_p <= w_mul_next;
                        if (r_count == c_LAST) begin
                            data_result    <= w_mul_next[WIDTH:1];
                            data_exception <= w_mul_ovf;
                            data_resultRDY <= 1'b1;
                            r_state        <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multdiv_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multdiv_seq_ctrl
//  Description : Self-checking bench for multdiv_seq_ctrl. Provides the shared
//                adder externally and compares against arithmetic products
//                (and quotients when MULTDIV_DIV_EN is defined).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multdiv_seq_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] adder_a;
    logic [31:0] adder_b;
    logic        adder_cin;
    logic [31:0] adder_result;
    logic        adder_overflow;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int errors = 0;
    int checks = 0;

    multdiv_seq_ctrl #(.WIDTH(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .adder_a        (adder_a),
        .adder_b        (adder_b),
        .adder_cin      (adder_cin),
        .adder_result   (adder_result),
        .adder_overflow (adder_overflow),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    // The ALU adder the sequencer borrows: plain add with signed overflow
    assign adder_result   = adder_a + adder_b + {31'b0, adder_cin};
    assign adder_overflow = (adder_a[31] == adder_b[31]) && (adder_result[31] != adder_a[31]);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one operation, optionally poke a second start at edge N+inject_at,
    // and check timing, result and exception against arithmetic expectations.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input bit mul, input bit div, input int inject_at,
                          input string tag);
        logic [31:0] exp_r;
        logic        exp_e;
        int          lat;
        longint      p;
        longint      q;
        bit          early_bad;
        if (mul) begin
            p     = longint'(signed'(a)) * longint'(signed'(b));
            exp_r = p[31:0];
            exp_e = (p != longint'(signed'(p[31:0])));
            lat   = 32;
        end else if (b == 32'd0) begin
            exp_r = 32'd0;
            exp_e = 1'b1;
            lat   = 1;
        end else begin
            q     = longint'(signed'(a)) / longint'(signed'(b));
            exp_r = q[31:0];
            exp_e = (q > 64'sd2147483647);
            lat   = 32;
        end
        @(negedge clock);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = mul;
        ctrl_DIV      = div;
        @(posedge clock); #1;                       // edge N
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
        check({tag, "_busy_start"}, {31'b0, busy}, 32'd1);
        early_bad = 1'b0;
        for (int k = 1; k < lat; k++) begin
            if (k == inject_at) begin
                ctrl_MULT     = 1'b1;
                ctrl_DIV      = 1'b1;
                data_operandA = 32'd7;
                data_operandB = 32'd7;
            end
            @(posedge clock); #1;                   // edge N+k
            ctrl_MULT = 1'b0;
            ctrl_DIV  = 1'b0;
            if (data_resultRDY !== 1'b0 || busy !== 1'b1) early_bad = 1'b1;
        end
        check({tag, "_no_early_rdy"}, {31'b0, early_bad}, 32'd0);
        @(posedge clock); #1;                       // edge N+lat
        check({tag, "_rdy"},    {31'b0, data_resultRDY}, 32'd1);
        check({tag, "_result"}, data_result, exp_r);
        check({tag, "_exc"},    {31'b0, data_exception}, {31'b0, exp_e});
        @(posedge clock); #1;                       // edge N+lat+1
        check({tag, "_rdy_off"},  {31'b0, data_resultRDY}, 32'd0);
        check({tag, "_busy_off"}, {31'b0, busy}, 32'd0);
        check({tag, "_hold"},     data_result, exp_r);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit seen_rdy;
        reset         = 1'b0;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = 32'd0;
        data_operandB = 32'd0;
        #2 reset = 1'b1;
        #1;
        check("rst_result", data_result, 32'd0);
        check("rst_exc",    {31'b0, data_exception}, 32'd0);
        check("rst_rdy",    {31'b0, data_resultRDY}, 32'd0);
        check("rst_busy",   {31'b0, busy}, 32'd0);
        check("rst_adder",  adder_a | adder_b | {31'b0, adder_cin}, 32'd0);
        repeat (2) @(posedge clock);
        @(negedge clock) reset = 1'b0;

        run_op(32'd3,          32'hFFFF_FFFC, 1'b1, 1'b0, 0, "m3xm4");
        run_op(32'h7FFF_FFFF,  32'd2,         1'b1, 1'b0, 0, "max_x2");
        run_op(32'h8000_0000,  32'hFFFF_FFFF, 1'b1, 1'b0, 0, "min_xm1");
        run_op(32'h8000_0000,  32'h8000_0000, 1'b1, 1'b0, 0, "min_xmin");
        run_op(32'd5,          32'd6,         1'b1, 1'b0, 10, "ignore_busy");
        run_op(32'hFFFF_FFFA,  32'd7,         1'b1, 1'b1, 0, "mult_wins");
        for (int i = 0; i < 8; i++)
            run_op($urandom, (i < 4) ? ($urandom & 32'h0000_FFFF) : $urandom,
                   1'b1, 1'b0, 0, "rand_mul");

`ifdef MULTDIV_DIV_EN
        run_op(32'd100,        32'hFFFF_FFF9, 1'b0, 1'b1, 0, "div_100_m7");
        run_op(32'd9,          32'd0,         1'b0, 1'b1, 0, "div_by0");
        run_op(32'h8000_0000,  32'hFFFF_FFFF, 1'b0, 1'b1, 0, "div_min_m1");
        run_op(32'hFFFF_FFF0,  32'h8000_0000, 1'b0, 1'b1, 0, "div_big_b");
        for (int i = 0; i < 6; i++)
            run_op($urandom, ($urandom & 32'h00FF_FFFF) | 32'd1, 1'b0, 1'b1, 0, "rand_div");
`endif

        // Idle adder port must be quiet between operations
        @(negedge clock);
        check("idle_adder", adder_a | adder_b | {31'b0, adder_cin}, 32'd0);

        // Asynchronous reset in the middle of a running multiply
        data_operandA = 32'h1234_5678;
        data_operandB = 32'h0000_0009;
        ctrl_MULT     = 1'b1;
        @(posedge clock); #1;
        ctrl_MULT = 1'b0;
        repeat (5) @(posedge clock);
        #3 reset = 1'b1;
        #1;
        check("arst_result", data_result, 32'd0);
        check("arst_exc",    {31'b0, data_exception}, 32'd0);
        check("arst_rdy",    {31'b0, data_resultRDY}, 32'd0);
        check("arst_busy",   {31'b0, busy}, 32'd0);
        check("arst_adder",  adder_a | adder_b | {31'b0, adder_cin}, 32'd0);
        @(posedge clock); #1;
        @(negedge clock) reset = 1'b0;
        seen_rdy = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clock); #1;
            if (data_resultRDY !== 1'b0 || busy !== 1'b0) seen_rdy = 1'b1;
        end
        check("arst_stays_idle", {31'b0, seen_rdy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
